// File: rtl/vx_credit_sender_if.sv
// vx_credit_sender_if: upstream valid/ready handshake plus the credit-controlled link.
interface vx_credit_sender_if #(
    parameter int DATAW = 1
);
    logic             valid_in;
    logic             ready_in;
    logic [DATAW-1:0] data_in;
    logic             valid_out;
    logic [DATAW-1:0] data_out;
    logic             credit_in;
    modport master (output valid_in, data_in, credit_in, input ready_in, valid_out, data_out);
    modport slave (input valid_in, data_in, credit_in, output ready_in, valid_out, data_out);
endinterface

// File: rtl/vx_credit_sender.sv
// vx_credit_sender: credit-based flow-control sender with optional registered link output.
module vx_credit_sender #(
    parameter int DATAW   = 1,
    parameter int CREDITS = 4,
    parameter int OUT_REG = 1,
    localparam int CNTW   = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    vx_credit_sender_if.slave bus,
    output logic [CNTW-1:0]   credits,
    output logic              idle,
    output logic              credit_err
);
    logic            send;
    logic            full;
    logic            overflow;
    logic [CNTW-1:0] credits_n;
    assign full         = credits == CNTW'(CREDITS);
    assign bus.ready_in = credits != '0;
    assign send         = bus.valid_in && bus.ready_in;
    // A credit returned with nothing outstanding is an error; the count saturates.
    assign overflow     = bus.credit_in && !send && full;
    assign credits_n    = overflow ? credits : credits - CNTW'(send) + CNTW'(bus.credit_in);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits    <= CNTW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            credits    <= credits_n;
            credit_err <= credit_err | overflow;
        end
    end
    generate
        if (OUT_REG != 0) begin : g_reg
            logic             valid_r;
            logic [DATAW-1:0] data_r;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_r <= 1'b0;
                    data_r  <= '0;
                end else begin
                    valid_r <= send;
                    if (send) data_r <= bus.data_in;
                end
            end
            assign bus.valid_out = valid_r;
            assign bus.data_out  = data_r;
            assign idle          = full && !valid_r;
        end else begin : g_comb
            // Gated by reset so the link stays quiet while reset is held.
            assign bus.valid_out = send && reset;
            assign bus.data_out  = reset ? bus.data_in : '0;
            assign idle          = full;
        end
    endgenerate
endmodule
